// File: rtl/ascii_frame_sequencer.sv
// Walks a COLS x ROWS luminance grid, quantises each cell to a glyph id and streams the LUT character, CR/LF per row.
// First byte valid 4 cycles after start; every byte (cell, CR, LF) is held stable until char_ready_in accepts it.
module ascii_frame_sequencer #(
   parameter int COLS   = 80,
   parameter int ROWS   = 60,
   parameter int ADDR_W = 13,
   parameter bit INVERT = 1'b0
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start_in,
   output logic [ADDR_W-1:0] lum_addr_out,
   input  logic [7:0]        lum_data_in,
   output logic [5:0]        lut_id_out,
   input  logic [7:0]        lut_char_in,
   output logic [7:0]        char_out,
   output logic              char_valid_out,
   input  logic              char_ready_in,
   output logic              busy_out,
   output logic              frame_done_out
);

   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_MAP, S_LOAD, S_SEND, S_CR, S_LF
   } state_t;

   state_t              state_q, state_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [5:0]          id_q, id_d;
   logic [7:0]          char_q, char_d;
   logic                vld_q, vld_d;
   logic                done_q, done_d;

   logic                accept;
   logic [7:0]          lum_eff;
   logic [13:0]         lum_prod;

   assign accept   = vld_q & char_ready_in;
   assign lum_eff  = INVERT ? (8'd255 - lum_data_in) : lum_data_in;
   // Scales 0..255 onto 48 glyph levels; ids 48..63 can never be produced.
   assign lum_prod = {6'd0, lum_eff} * 14'd48;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         addr_q  <= '0;
         id_q    <= '0;
         char_q  <= '0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         addr_q  <= addr_d;
         id_q    <= id_d;
         char_q  <= char_d;
         vld_q   <= vld_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start_in) state_d = S_FETCH;
         S_FETCH: state_d = S_MAP;
         S_MAP:   state_d = S_LOAD;
         S_LOAD:  state_d = S_SEND;
         S_SEND:  if (accept) state_d = (col_q == COL_LAST) ? S_CR : S_FETCH;
         S_CR:    if (accept) state_d = S_LF;
         S_LF:    if (accept) state_d = (row_q == ROW_LAST) ? S_IDLE : S_FETCH;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      addr_d = addr_q;
      id_d   = id_q;
      char_d = char_q;
      vld_d  = vld_q;
      done_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_in) begin
               col_d  = '0;
               row_d  = '0;
               addr_d = '0;
            end
         end
         S_MAP: id_d = lum_prod[13:8];
         S_LOAD: begin
            char_d = lut_char_in;
            vld_d  = 1'b1;
         end
         S_SEND: begin
            if (accept) begin
               if (col_q == COL_LAST) begin
                  char_d = CHAR_CR;
               end else begin
                  col_d  = col_q + COL_W'(1);
                  addr_d = addr_q + ADDR_W'(1);
                  vld_d  = 1'b0;
               end
            end
         end
         S_CR: if (accept) char_d = CHAR_LF;
         S_LF: begin
            if (accept) begin
               vld_d = 1'b0;
               if (row_q == ROW_LAST) begin
                  done_d = 1'b1;
               end else begin
                  row_d  = row_q + ROW_W'(1);
                  col_d  = '0;
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   assign lum_addr_out   = addr_q;
   assign lut_id_out     = id_q;
   assign char_out       = char_q;
   assign char_valid_out = vld_q;
   assign busy_out       = (state_q != S_IDLE);
   assign frame_done_out = done_q;

endmodule

// File: tb/tb_ascii_frame_sequencer.sv
// Bench for ascii_frame_sequencer: 4x2 frames (directed and random) plus a 2x1 inverted instance.
module tb_ascii_frame_sequencer;

   localparam int COLS   = 4;
   localparam int ROWS   = 2;
   localparam int ADDR_W = 3;
   localparam int NCELL  = COLS * ROWS;
   localparam int NBYTE  = NCELL + 2 * ROWS;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int done_seen = 0;

   // Stand-in character table for ascii_lut: known glyphs at the ids the directed cases hit.
   function automatic logic [7:0] lut(input logic [5:0] id);
      case (id)
         6'd0:    return 8'h20;
         6'd1:    return 8'h2E;
         6'd12:   return 8'h7C;
         6'd24:   return 8'h65;
         6'd47:   return 8'h51;
         default: return 8'h80 + {2'b00, id};
      endcase
   endfunction

   // Luminance scaled onto 48 levels, floor(l*48/256), with optional inversion.
   function automatic logic [5:0] glyph(input logic [7:0] lum, input bit inv);
      int l;
      l = inv ? (255 - int'(lum)) : int'(lum);
      return 6'((l * 48) / 256);
   endfunction

   // ---------------- DUT A: 4x2, non-inverted ----------------
   logic              start_a = 1'b0, ready_a = 1'b0;
   logic [ADDR_W-1:0] addr_a;
   logic [7:0]        lum_a, lutc_a, char_a;
   logic [5:0]        id_a;
   logic              vld_a, busy_a, done_a;
   logic [7:0]        mem_a [NCELL];

   always @(posedge clk) lum_a <= mem_a[addr_a];
   assign lutc_a = lut(id_a);

   ascii_frame_sequencer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .INVERT(1'b0)) dut_a (
      .clk_in(clk), .rst_in(rst), .start_in(start_a),
      .lum_addr_out(addr_a), .lum_data_in(lum_a),
      .lut_id_out(id_a), .lut_char_in(lutc_a),
      .char_out(char_a), .char_valid_out(vld_a), .char_ready_in(ready_a),
      .busy_out(busy_a), .frame_done_out(done_a)
   );

   // ---------------- DUT B: 2x1, inverted ----------------
   logic       start_b = 1'b0, ready_b = 1'b1;
   logic [0:0] addr_b;
   logic [7:0] lum_b, lutc_b, char_b;
   logic [5:0] id_b;
   logic       vld_b, busy_b, done_b;
   logic [7:0] mem_b [2];

   always @(posedge clk) lum_b <= mem_b[addr_b];
   assign lutc_b = lut(id_b);

   ascii_frame_sequencer #(.COLS(2), .ROWS(1), .ADDR_W(1), .INVERT(1'b1)) dut_b (
      .clk_in(clk), .rst_in(rst), .start_in(start_b),
      .lum_addr_out(addr_b), .lum_data_in(lum_b),
      .lut_id_out(id_b), .lut_char_in(lutc_b),
      .char_out(char_b), .char_valid_out(vld_b), .char_ready_in(ready_b),
      .busy_out(busy_b), .frame_done_out(done_b)
   );

   // Expected byte stream and the address that must be presented with each byte.
   logic [7:0] exp_b [$];
   int         exp_ad [$];

   function automatic void build_expect();
      exp_b.delete();
      exp_ad.delete();
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            exp_b.push_back(lut(glyph(mem_a[r*COLS+c], 1'b0)));
            exp_ad.push_back(r*COLS + c);
         end
         exp_b.push_back(8'h0D);
         exp_ad.push_back(r*COLS + COLS - 1);
         exp_b.push_back(8'h0A);
         exp_ad.push_back(r*COLS + COLS - 1);
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_a();
      chk("rst_addr",  32'(addr_a), 32'd0);
      chk("rst_id",    32'(id_a),   32'd0);
      chk("rst_char",  32'(char_a), 32'd0);
      chk("rst_valid", 32'(vld_a),  32'd0);
      chk("rst_busy",  32'(busy_a), 32'd0);
      chk("rst_done",  32'(done_a), 32'd0);
   endtask

   // Ready-low cycles to insert once a byte is offered.
   function automatic int plan(input bit directed, input int nb);
      if (directed) return (nb == 1 || nb == 4) ? 5 : 0;
      return int'($urandom_range(0, 3));
   endfunction

   // One clock on DUT A: report a handshake, and verify a stalled byte was held.
   task automatic tick(output bit hs, output logic [7:0] hc, output logic [ADDR_W-1:0] ha);
      bit stalled;
      hs      = vld_a && ready_a;
      stalled = vld_a && !ready_a;
      hc      = char_a;
      ha      = addr_a;
      @(posedge clk);
      #1;
      if (done_a) done_seen++;
      if (stalled) begin
         chk("hold_valid", 32'(vld_a),  32'd1);
         chk("hold_char",  32'(char_a), 32'(hc));
         chk("hold_addr",  32'(addr_a), 32'(ha));
      end
   endtask

   task automatic run_frame(input bit directed, input int abort_byte, input bit poke_start);
      int nb, cyc, first_v, stall;
      bit hs;
      logic [7:0] hc;
      logic [ADDR_W-1:0] ha;
      build_expect();
      nb = 0; cyc = 0; first_v = -1; done_seen = 0;
      start_a = 1'b1;
      ready_a = 1'b0;
      tick(hs, hc, ha);
      start_a = 1'b0;
      chk("busy_on_start", 32'(busy_a), 32'd1);
      stall = plan(directed, 0);
      while (nb < NBYTE && cyc < 500) begin
         if (abort_byte == nb && vld_a) begin
            #2 rst = 1'b1;
            #1 chk_reset_a();
            @(negedge clk) rst = 1'b0;
            @(posedge clk);
            #1 chk("abort_stays_idle", 32'(busy_a), 32'd0);
            return;
         end
         start_a = poke_start && (nb == 2);
         if (vld_a && stall > 0) begin
            ready_a = 1'b0;
            stall--;
         end else if (vld_a) begin
            ready_a = 1'b1;
         end else begin
            ready_a = 1'($urandom_range(0, 1));
         end
         tick(hs, hc, ha);
         cyc++;
         if (first_v < 0 && vld_a) first_v = cyc;
         if (hs) begin
            chk("byte", 32'(hc), 32'(exp_b[nb]));
            chk("addr", 32'(ha), exp_ad[nb]);
            nb++;
            if (nb == NBYTE) begin
               chk("done_after_last_lf", 32'(done_a), 32'd1);
               chk("busy_low_at_done",   32'(busy_a), 32'd0);
            end else begin
               stall = plan(directed, nb);
            end
         end
      end
      start_a = 1'b0;
      ready_a = 1'b1;
      chk("byte_count", nb, NBYTE);
      chk("first_valid_latency", first_v, 32'd3);
      repeat (4) tick(hs, hc, ha);
      chk("done_pulse_count", done_seen, 32'd1);
      chk("idle_after_frame", 32'(busy_a | vld_a), 32'd0);
   endtask

   logic [7:0] got [$];
   int         done_b_cnt;

   initial begin
      // Asynchronous reset with no clock edge in between.
      #2 rst = 1'b1;
      #1 chk_reset_a();
      chk("rst_busy_b", 32'(busy_b), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed quantisation frame with backpressure on cell 1 and on the first CR.
      mem_a = '{8'd0, 8'd255, 8'd128, 8'd64, 8'd5, 8'd6, 8'd200, 8'd100};
      run_frame(1'b1, -1, 1'b0);

      // Random frame with a start pulse while busy.
      for (int i = 0; i < NCELL; i++) mem_a[i] = 8'($urandom_range(0, 255));
      run_frame(1'b0, -1, 1'b1);

      // Reset during SEND of cell 5, then a fresh frame must restart at cell 0.
      mem_a = '{8'd0, 8'd255, 8'd128, 8'd64, 8'd5, 8'd6, 8'd200, 8'd100};
      run_frame(1'b1, 7, 1'b0);
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < NCELL; i++) mem_a[i] = 8'($urandom_range(0, 255));
         run_frame(1'b0, -1, 1'b0);
      end

      // Inverted 2x1 instance: luminance {0,255}.
      mem_b = '{8'd0, 8'd255};
      got.delete();
      done_b_cnt = 0;
      start_b = 1'b1;
      @(posedge clk);
      #1 start_b = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (vld_b) got.push_back(char_b);
         @(posedge clk);
         #1;
         if (done_b) done_b_cnt++;
      end
      chk("inv_byte_count", got.size(), 32'd4);
      if (got.size() == 4) begin
         chk("inv_byte0", 32'(got[0]), 32'(lut(glyph(8'd0, 1'b1))));
         chk("inv_byte1", 32'(got[1]), 32'(lut(glyph(8'd255, 1'b1))));
         chk("inv_cr",    32'(got[2]), 32'h0D);
         chk("inv_lf",    32'(got[3]), 32'h0A);
      end
      chk("inv_done_count", done_b_cnt, 32'd1);
      chk("inv_idle", 32'(busy_b), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ascii_frame_sequencer.md
# ascii_frame_sequencer

Frame-level controller that walks a COLS×ROWS grid of per-cell average luminance values, quantises each value to a 6-bit glyph index, and drives the `ascii_lut` character lookup. It emits the resulting ASCII characters, with CR/LF at each row end, on a valid/ready byte stream. It sits between the cell-luminance BRAM and the UART/text-buffer sink.

## Interface

Parameters:
- COLS, 80, cells per row (≥2)
- ROWS, 60, rows per frame (≥1)
- ADDR_W, 13, cell-address width; must satisfy 2^ADDR_W ≥ COLS*ROWS
- INVERT, 0, when 1 the luminance is replaced by 255−lum before quantisation

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- start_in  in  1  begins a frame when sampled high in IDLE; ignored otherwise
- lum_addr_out  out  ADDR_W  cell index row*COLS+col, registered, to the synchronous BRAM
- lum_data_in  in  8  cell luminance; valid the cycle after lum_addr_out changes (1-cycle read latency)
- lut_id_out  out  6  glyph index to `ascii_lut` id input, registered
- lut_char_in  in  8  `ascii_lut` character output (combinational from lut_id_out)
- char_out  out  8  output byte, registered
- char_valid_out  out  1  char_out valid
- char_ready_in  in  1  sink accepts byte when high together with valid
- busy_out  out  1  high in every state except IDLE
- frame_done_out  out  1  one-cycle pulse after the last LF of a frame is accepted

## Operation

- States: IDLE, FETCH, MAP, LOAD, SEND, CR, LF.
- IDLE: if start_in=1, set col=0, row=0, lum_addr_out=0, go to FETCH.
- FETCH: address is stable; BRAM is reading. Next state is MAP.
- MAP: l = INVERT ? 255−lum_data_in : lum_data_in; lut_id_out ← (l*48)>>8, using a 14-bit product. The result range is 0..47, so the LUT's undefined ids 48..63 are never driven. Next state is LOAD.
- LOAD: char_out ← lut_char_in; char_valid_out ← 1; next state is SEND.
- SEND: hold char_out and valid until char_valid_out & char_ready_in.
  - On acceptance with col<COLS−1: col++, lum_addr_out++, go to FETCH.
  - On acceptance with col=COLS−1: load char_out=8'h0D with valid held, go to CR.
- CR: hold until accepted. On acceptance, char_out=8'h0A, go to LF.
- LF: hold until accepted. On acceptance:
  - If row<ROWS−1: row++, col=0, lum_addr_out++, deassert valid, go to FETCH.
  - If row=ROWS−1: deassert valid, pulse frame_done_out, go to IDLE.
- Stream rule: once char_valid_out rises, char_out must not change and valid must not drop until the handshake completes.
- A frame emits exactly COLS*ROWS + 2*ROWS bytes.
- start_in while busy_out=1 is ignored. No queueing.
- Reset (any state, any cycle) asynchronously forces IDLE, col=row=0, and all outputs to reset values. An interrupted frame is abandoned; the next start_in restarts at cell 0.

## Timing

- Reset values: lum_addr_out=0, lut_id_out=0, char_out=8'h00, char_valid_out=0, busy_out=0, frame_done_out=0.
- start_in sampled at edge N: FETCH during cycle N+1, MAP N+2, LOAD N+3, char_valid_out high from cycle N+4.
- Per-cell minimum period is 4 cycles (FETCH, MAP, LOAD, SEND with ready=1). CR and LF each take a minimum of 1 cycle.
- Valid is contiguous across SEND→CR→LF. Between cells and after LF, valid drops for 3 cycles (FETCH/MAP/LOAD).
- frame_done_out is high for exactly the cycle after the final LF handshake. busy_out is low in that same cycle.
- lut_id_out changes only on the MAP→LOAD edge. The LUT path is combinational within the LOAD cycle only.

## Test plan

- Reset: assert rst_in mid-cycle with no clock edge. Required: all outputs equal reset values immediately; busy_out=0.
- Quantisation mapping, COLS=4, ROWS=2, INVERT=0, row 0 luminance {0,255,128,64}, ready=1. Required byte stream: " ", "Q", "e", "|", 0x0D, 0x0A. Also lum 5→id 0 (" ") and lum 6→id 1 (".").
- Full frame, 4×2 as above: start pulse. Required: exactly 12 handshakes, lum_addr_out visiting 0..7 in order, and a single frame_done_out pulse after the 12th handshake.
- Backpressure: hold char_ready_in=0 for 5 cycles during SEND of cell 1 and during CR. Required: char_out and char_valid_out stable, lum_addr_out not advancing, no byte lost or duplicated.
- Start while busy and mid-frame reset:
  - start_in pulsed during a frame. Required: ignored, frame completes normally.
  - rst_in asserted in SEND of cell 5. Required: outputs zero asynchronously; a new start_in restarts at lum_addr_out=0.
- INVERT=1: luminance {0,255}. Required: "Q" then " ".
